cb_1: RTL and testbench



---
 rtl/cb_1_pkg.sv | 6 +
 rtl/cb_1_sync.sv | 19 +
 rtl/cb_1.sv | 36 +++
 tb/tb_cb_1.sv | 78 +++++++
 4 files changed

// File: rtl/cb_1_pkg.sv
// cb_1_pkg: shared types and constants for the cb_1 lamp-control cell
package cb_1_pkg;
   typedef logic [2:0] cb_1_idx_t;
   localparam logic [7:0] CB_1_TRUTH_DEFAULT = 8'hBA;
   localparam int CB_1_SYNC_STAGES = 2;
endpackage

// File: rtl/cb_1_sync.sv
// cb_1_sync: single-bit multi-flop synchroniser, stages cleared to 0 by rst
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   d_i  in  asynchronous input bit
//   q_o  out synchronised bit (CB_1_SYNC_STAGES cycles later)
module cb_1_sync
   import cb_1_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [CB_1_SYNC_STAGES-1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[CB_1_SYNC_STAGES-2:0], d_i};
   always_ff @(posedge clk)
      sync_q <= rst ? '0 : sync_d;
   assign q_o = sync_q[CB_1_SYNC_STAGES-1];
endmodule

// File: rtl/cb_1.sv
// cb_1: lamp control, l = TRUTH[{d,x,a}] registered; optional input sync via CB_1_INPUT_SYNC_EN
//   TRUTH  param 8-bit lookup table, bit index = {d,x,a}
//   clk    in    rising-edge clock
//   rst    in    synchronous active-high reset (clears l and synchronisers)
//   d      in    door open
//   x      in    disarm / key present
//   a      in    panic / alarm request
//   l      out   lamp, registered
module cb_1
   import cb_1_pkg::*;
#(
   parameter logic [7:0] TRUTH = CB_1_TRUTH_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic x,
   input  logic a,
   output logic l
);
   cb_1_idx_t idx;
   logic      l_q, l_d;
`ifdef CB_1_INPUT_SYNC_EN
   logic d_s, x_s, a_s;
   cb_1_sync u_sync_d (.clk(clk), .rst(rst), .d_i(d), .q_o(d_s));
   cb_1_sync u_sync_x (.clk(clk), .rst(rst), .d_i(x), .q_o(x_s));
   cb_1_sync u_sync_a (.clk(clk), .rst(rst), .d_i(a), .q_o(a_s));
   assign idx = {d_s, x_s, a_s};
`else
   assign idx = {d, x, a};
`endif
   always_comb l_d = TRUTH[idx];
   always_ff @(posedge clk)
      l_q <= rst ? 1'b0 : l_d;
   assign l = l_q;
endmodule

// File: tb/tb_cb_1.sv
// tb_cb_1: randomized + directed self-checking bench for cb_1 against a history-based model
module tb_cb_1;
`ifdef CB_1_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d = 1'b0, x = 1'b0, a = 1'b0;
   logic l_def, l_cust;
   int total = 0, bad = 0;
   logic       hist_rst[$];
   logic [2:0] hist_idx[$];

   cb_1 u_def (.clk(clk), .rst(rst), .d(d), .x(x), .a(a), .l(l_def));
   cb_1 #(.TRUTH(8'h01)) u_cust (.clk(clk), .rst(rst), .d(d), .x(x), .a(a), .l(l_cust));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b want=%b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Lamp after the latest edge: reset at that edge forces 0; a reset anywhere in
   // the input pipeline window means the decode saw cleared (000) inputs; otherwise
   // the table entry for the inputs sampled LAT-1 edges earlier.
   function automatic logic model(input logic [7:0] t);
      int k = hist_rst.size() - 1;
      if (hist_rst[k]) return 1'b0;
      for (int j = 1; j < LAT; j++)
         if (k - j < 0 || hist_rst[k-j]) return t[0];
      return t[hist_idx[k-LAT+1]];
   endfunction

   task automatic step(input string tag);
      @(posedge clk);
      hist_rst.push_back(rst);
      hist_idx.push_back({d, x, a});
      #1;
      chk({tag, "/def"}, l_def, model(8'hBA));
      chk({tag, "/cust"}, l_cust, model(8'h01));
   endtask

   task automatic drive(input logic [2:0] v, input logic r, input int n, input string tag);
      {d, x, a} = v;
      rst = r;
      repeat (n) step(tag);
   endtask

   initial begin
      drive(3'b111, 1'b1, 2, "reset");
      drive(3'b111, 1'b0, LAT + 2, "release");
      for (int i = 0; i < 8; i++) drive(3'(i), 1'b0, LAT + 1, "sweep");
      for (int i = 0; i < 8; i++) drive(3'(i), 1'b0, 1, "sweep1");
      drive(3'b100, 1'b0, LAT + 1, "door");
      drive(3'b110, 1'b0, LAT + 1, "disarm");
      drive(3'b100, 1'b0, LAT + 1, "rearm");
      drive(3'b111, 1'b0, LAT + 1, "panic");
      drive(3'b100, 1'b0, LAT + 1, "pre_midrst");
      drive(3'b100, 1'b1, 1, "midrst");
      drive(3'b100, 1'b0, LAT + 2, "post_midrst");
      drive(3'b000, 1'b0, LAT + 1, "pre_pulse");
      drive(3'b001, 1'b0, 1, "pulse");
      drive(3'b000, 1'b0, LAT + 2, "post_pulse");
      repeat (300) begin
         {d, x, a} = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 15) == 0);
         step("rand");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
